alu_issue: RTL and testbench
============================

# alu_issue

Issue stage that sits between decode and the combinational ALU in the pipelined CPU. It accepts one decoded instruction per cycle with its register operands, generates the 13-bit one-hot ALU control word and both ALU source operands, and holds them in a two-entry skid buffer behind a valid/ready handshake. The ALU consumes the registered outputs directly.

## Interface
Parameters:
- None. All widths are fixed: 32-bit datapath, 13-bit control, 5-bit register index.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  drop all buffered entries and the current input.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle. Registered.
- in_inst  in  32  raw instruction word.
- in_rs_value  in  32  GPR[rs].
- in_rt_value  in  32  GPR[rt].
- out_valid  out  1  ALU operands valid.
- out_ready  in  1  downstream consumes this cycle.
- out_alu_control  out  13  one-hot control word. Bit 12 nand, 11 add, 10 sub, 9 slt, 8 sltu, 7 and, 6 nor, 5 or, 4 xor, 3 sll, 2 srl, 1 sra, 0 lui.
- out_alu_src1  out  32  first operand. For shifts this is the shift amount in [4:0].
- out_alu_src2  out  32  second operand. For shifts this is the shifted value.
- out_dest  out  5  destination register index.
- out_illegal  out  1  opcode/funct not in the supported set.

## Operation
- Decode is combinational on the input side. Only the decoded payload is stored: control, src1, src2, dest, illegal (83 bits).
- SPECIAL (op=0), dest=rd:
  - funct 21 ADDU add, 23 SUBU sub, 2A SLT, 2B SLTU, 24 AND, 27 NOR, 25 OR, 26 XOR, 3F NAND.
  - For these: src1=rs_value, src2=rt_value.
- SPECIAL shifts, dest=rd, src2=rt_value:
  - funct 00 SLL, 02 SRL, 03 SRA: src1={27'b0,shamt}.
  - funct 04 SLLV, 06 SRLV, 07 SRAV: src1=rs_value.
- I-type, dest=rt, src1=rs_value:
  - op 09 ADDIU add, 0A SLTI, 0B SLTIU: src2=sign-extended imm16.
  - op 0C ANDI, 0D ORI, 0E XORI: src2=zero-extended imm16.
  - op 0F LUI: lui, src2={16'b0,imm16}.
- Any other encoding: control=0, illegal=1, src1=src2=0, dest=0. The ALU then yields 0.
- Buffer has three states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main entry valid, in_ready=1.
  - FULL: main and skid entries valid, in_ready=0.
- State transitions:
  - EMPTY + accept → ONE.
  - ONE + accept without consume → FULL. The new entry goes to skid.
  - ONE + accept + consume → ONE. The new entry goes to main.
  - ONE + consume only → EMPTY.
  - FULL + consume → ONE. Skid moves to main. No accept is possible because in_ready=0.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- Ordering is strict FIFO. No entry is ever dropped or duplicated except on flush.
- flush has priority over every other event. Next state is EMPTY, and an input presented in the same cycle is discarded.
- rst behaves like flush and also zeroes the payload registers.

## Timing
- Latency: an input accepted in cycle N appears on out_* in cycle N+1.
- Throughput: one instruction per cycle while out_ready=1.
- After rst, the following cycle shows out_valid=0, in_ready=1, and all out_* payload = 0.
- in_ready is a flop: in_ready(N+1) = (state(N+1) != FULL). It never depends combinationally on out_ready.
- out_* change only on a consume, on an accept into EMPTY, or on flush/rst. They are stable while out_valid & ~out_ready.
- When the buffer is FULL and out_ready rises, skid data is presented in the next cycle. in_ready returns to 1 in that same next cycle.
- When rst is asserted mid-stream, both entries are lost and the next cycle equals the post-reset state.

## Structure
- Shared package holds:
  - the alu_control bit-index constants and the 13-bit width;
  - opcode and funct localparams, including NAND funct 6'h3F;
  - a decode function returning the 83-bit payload.
- The ALU and the decode/issue logic both use this package.
- One sub-module is natural: alu_issue_skid, a width-parameterised two-entry skid buffer with valid/ready, flush and rst.
- alu_issue instantiates the decode function and alu_issue_skid.

## Test plan
- ADDIU: in_inst=32'h2509FFFF, rs_value=5 → next cycle out_valid=1, control=13'h0800, src1=5, src2=32'hFFFFFFFF, dest=9.
- SLL: in_inst=32'h00095100, rt_value=32'h0000000F → control=13'h0008, src1=4, src2=32'h0F, dest=10.
- LUI: in_inst=32'h3C011234 → control=13'h0001, src2=32'h00001234, dest=1, illegal=0.
- Illegal: in_inst=32'hFC000000 → control=0, illegal=1.
- Backpressure: stream ORI, XORI, ANDI with out_ready=0 for 3 cycles.
  - in_ready drops the cycle after the second accept, and the third instruction is held upstream.
  - When out_ready goes to 1, outputs appear in order ORI, XORI, ANDI on consecutive cycles, with nothing lost.
- Flush when FULL with in_valid=1: next cycle out_valid=0, in_ready=1. No entry, including the concurrent input, ever appears. rst mid-stream gives the same result.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: control-word bit positions,
// opcode/funct encodings, the issued payload layout and the decode function.
package alu_issue_pkg;

    localparam int XLEN          = 32;
    localparam int ALU_CTRL_W    = 13;
    localparam int REG_IDX_W     = 5;

    localparam int ALU_NAND = 12;
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_NAND = 6'h3F;

    typedef struct packed {
        logic [ALU_CTRL_W-1:0] control;
        logic [XLEN-1:0]       src1;
        logic [XLEN-1:0]       src2;
        logic [REG_IDX_W-1:0]  dest;
        logic                  illegal;
    } alu_payload_t;

    localparam int PAYLOAD_W = $bits(alu_payload_t);

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // low16 carries rd/shamt/funct for R-type and imm16 for I-type.
    function automatic alu_payload_t alu_decode(
        input logic [5:0]           op,
        input logic [REG_IDX_W-1:0] rt_idx,
        input logic [15:0]          low16,
        input logic [XLEN-1:0]      rs_value,
        input logic [XLEN-1:0]      rt_value
    );
        alu_payload_t      p;
        alu_payload_t      bad;
        logic signed [15:0] imm_s;
        logic [XLEN-1:0]   imm_sext;
        logic [XLEN-1:0]   imm_zext;

        bad         = '0;
        bad.illegal = 1'b1;
        imm_s       = low16;
        imm_sext    = {{16{imm_s[15]}}, imm_s};
        imm_zext    = {16'b0, low16};

        p      = '0;
        p.src1 = rs_value;
        case (op)
            OP_SPECIAL: begin
                p.dest = low16[15:11];
                p.src2 = rt_value;
                case (low16[5:0])
                    FN_ADDU: p.control[ALU_ADD]  = 1'b1;
                    FN_SUBU: p.control[ALU_SUB]  = 1'b1;
                    FN_SLT:  p.control[ALU_SLT]  = 1'b1;
                    FN_SLTU: p.control[ALU_SLTU] = 1'b1;
                    FN_AND:  p.control[ALU_AND]  = 1'b1;
                    FN_NOR:  p.control[ALU_NOR]  = 1'b1;
                    FN_OR:   p.control[ALU_OR]   = 1'b1;
                    FN_XOR:  p.control[ALU_XOR]  = 1'b1;
                    FN_NAND: p.control[ALU_NAND] = 1'b1;
                    FN_SLL: begin
                        p.control[ALU_SLL] = 1'b1;
                        p.src1 = {27'b0, low16[10:6]};
                    end
                    FN_SRL: begin
                        p.control[ALU_SRL] = 1'b1;
                        p.src1 = {27'b0, low16[10:6]};
                    end
                    FN_SRA: begin
                        p.control[ALU_SRA] = 1'b1;
                        p.src1 = {27'b0, low16[10:6]};
                    end
                    FN_SLLV: p.control[ALU_SLL] = 1'b1;
                    FN_SRLV: p.control[ALU_SRL] = 1'b1;
                    FN_SRAV: p.control[ALU_SRA] = 1'b1;
                    default: p = bad;
                endcase
            end
            OP_ADDIU: begin p.control[ALU_ADD]  = 1'b1; p.src2 = imm_sext; p.dest = rt_idx; end
            OP_SLTI:  begin p.control[ALU_SLT]  = 1'b1; p.src2 = imm_sext; p.dest = rt_idx; end
            OP_SLTIU: begin p.control[ALU_SLTU] = 1'b1; p.src2 = imm_sext; p.dest = rt_idx; end
            OP_ANDI:  begin p.control[ALU_AND]  = 1'b1; p.src2 = imm_zext; p.dest = rt_idx; end
            OP_ORI:   begin p.control[ALU_OR]   = 1'b1; p.src2 = imm_zext; p.dest = rt_idx; end
            OP_XORI:  begin p.control[ALU_XOR]  = 1'b1; p.src2 = imm_zext; p.dest = rt_idx; end
            OP_LUI:   begin p.control[ALU_LUI]  = 1'b1; p.src2 = imm_zext; p.dest = rt_idx; end
            default:  p = bad;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// Two-entry skid buffer: main entry drives the outputs, skid entry absorbs the
// one extra beat that arrives before the registered in_ready can fall.
module alu_issue_skid
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 83
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    skid_state_t       state;
    logic [DATA_W-1:0] main_p0;
    logic [DATA_W-1:0] skid_p1;
    logic              accept;
    logic              consume;

    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;
    assign out_data = main_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SKID_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_p0   <= '0;
            skid_p1   <= '0;
        end else if (flush) begin
            state     <= SKID_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        main_p0   <= in_data;
                        out_valid <= 1'b1;
                        state     <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && !consume) begin
                        skid_p1  <= in_data;
                        in_ready <= 1'b0;
                        state    <= SKID_FULL;
                    end else if (accept && consume) begin
                        main_p0 <= in_data;
                    end else if (consume) begin
                        out_valid <= 1'b0;
                        state     <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (consume) begin
                        main_p0  <= skid_p1;
                        in_ready <= 1'b1;
                        state    <= SKID_ONE;
                    end
                end
                default: begin
                    state     <= SKID_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decodes one instruction per cycle into ALU control and operands
// and registers the result behind a valid/ready skid buffer.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_inst,
    input  logic [XLEN-1:0]       in_rs_value,
    input  logic [XLEN-1:0]       in_rt_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ALU_CTRL_W-1:0] out_alu_control,
    output logic [XLEN-1:0]       out_alu_src1,
    output logic [XLEN-1:0]       out_alu_src2,
    output logic [REG_IDX_W-1:0]  out_dest,
    output logic                  out_illegal
);

    alu_payload_t dec_p0;
    alu_payload_t issued_p1;
    logic         unused_rs_idx;

    // The rs index is not needed: its value already arrives on in_rs_value.
    assign unused_rs_idx = ^in_inst[25:21];

    always_comb begin
        dec_p0 = alu_decode(in_inst[31:26], in_inst[20:16], in_inst[15:0],
                            in_rs_value, in_rt_value);
    end

    alu_issue_skid #(
        .DATA_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec_p0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (issued_p1)
    );

    assign out_alu_control = issued_p1.control;
    assign out_alu_src1    = issued_p1.src1;
    assign out_alu_src2    = issued_p1.src2;
    assign out_dest        = issued_p1.dest;
    assign out_illegal     = issued_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure ordering,
// flush and mid-stream reset.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs_value;
    logic [31:0] in_rt_value;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_alu_control;
    logic [31:0] out_alu_src1;
    logic [31:0] out_alu_src2;
    logic [4:0]  out_dest;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_inst         (in_inst),
        .in_rs_value     (in_rs_value),
        .in_rt_value     (in_rt_value),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_alu_control (out_alu_control),
        .out_alu_src1    (out_alu_src1),
        .out_alu_src2    (out_alu_src2),
        .out_dest        (out_dest),
        .out_illegal     (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [12:0] ctrl, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [4:0] dst, input logic ill);
        chk({tag, ".valid"},   {31'b0, out_valid},   32'd1);
        chk({tag, ".control"}, {19'b0, out_alu_control}, {19'b0, ctrl});
        chk({tag, ".src1"},    out_alu_src1, s1);
        chk({tag, ".src2"},    out_alu_src2, s2);
        chk({tag, ".dest"},    {27'b0, out_dest}, {27'b0, dst});
        chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".in_ready"},  {31'b0, in_ready},  32'd1);
        chk({tag, ".control"},   {19'b0, out_alu_control}, 32'd0);
        chk({tag, ".src1"},      out_alu_src1, 32'd0);
        chk({tag, ".src2"},      out_alu_src2, 32'd0);
        chk({tag, ".dest"},      {27'b0, out_dest}, 32'd0);
        chk({tag, ".illegal"},   {31'b0, out_illegal}, 32'd0);
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
        in_valid    = 1'b1;
        in_inst     = inst;
        in_rs_value = rs;
        in_rt_value = rt;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_rs_value = '0; in_rt_value = '0;
        step(); step();
        rst = 1'b0;
        chk_reset_state("reset");

        // Back-to-back decode with out_ready held high
        out_ready = 1'b1;
        present(32'h2509FFFF, 32'd5, 32'd0);
        step();
        chk_out("addiu", 13'h0800, 32'd5, 32'hFFFFFFFF, 5'd9, 1'b0);
        present(32'h00095100, 32'd7, 32'h0000000F);
        step();
        chk_out("sll", 13'h0008, 32'd4, 32'h0000000F, 5'd10, 1'b0);
        present(32'h3C011234, 32'h00000011, 32'd0);
        step();
        chk_out("lui", 13'h0001, 32'h00000011, 32'h00001234, 5'd1, 1'b0);
        present(32'hFC000000, 32'h12345678, 32'h9ABCDEF0);
        step();
        chk_out("illegal", 13'h0000, 32'd0, 32'd0, 5'd0, 1'b1);
        present(32'h00642807, 32'h00000003, 32'h80000000);
        step();
        chk_out("srav", 13'h0002, 32'h00000003, 32'h80000000, 5'd5, 1'b0);
        present(32'h0022183F, 32'hF0F0F0F0, 32'hFF00FF00);
        step();
        chk_out("nand", 13'h1000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd3, 1'b0);
        present(32'h28268000, 32'h00000001, 32'd0);
        step();
        chk_out("slti", 13'h0200, 32'h00000001, 32'hFFFF8000, 5'd6, 1'b0);
        in_valid = 1'b0;
        step();
        chk("drain.out_valid", {31'b0, out_valid}, 32'd0);
        chk("drain.in_ready",  {31'b0, in_ready},  32'd1);

        // Backpressure: ORI, XORI, ANDI against a stalled consumer
        out_ready = 1'b0;
        present(32'h342200F0, 32'hA0A00000, 32'd0);
        step();
        chk_out("bp.ori0", 13'h0020, 32'hA0A00000, 32'h000000F0, 5'd2, 1'b0);
        chk("bp.ready0", {31'b0, in_ready}, 32'd1);
        present(32'h38238001, 32'hA0A00000, 32'd0);
        step();
        chk("bp.ready1", {31'b0, in_ready}, 32'd0);
        chk_out("bp.ori1", 13'h0020, 32'hA0A00000, 32'h000000F0, 5'd2, 1'b0);
        present(32'h3024FFFF, 32'hA0A00000, 32'd0);
        step();
        chk("bp.ready2", {31'b0, in_ready}, 32'd0);
        chk_out("bp.ori2", 13'h0020, 32'hA0A00000, 32'h000000F0, 5'd2, 1'b0);
        out_ready = 1'b1;
        step();
        chk_out("bp.xori", 13'h0010, 32'hA0A00000, 32'h00008001, 5'd3, 1'b0);
        chk("bp.ready3", {31'b0, in_ready}, 32'd1);
        step();
        chk_out("bp.andi", 13'h0080, 32'hA0A00000, 32'h0000FFFF, 5'd4, 1'b0);
        in_valid = 1'b0;
        step();
        chk("bp.empty", {31'b0, out_valid}, 32'd0);

        // Flush while FULL with a concurrent input
        out_ready = 1'b0;
        present(32'h2509FFFF, 32'd5, 32'd0);
        step();
        present(32'h00095100, 32'd7, 32'h0000000F);
        step();
        chk("fl.full", {31'b0, in_ready}, 32'd0);
        present(32'h3C011234, 32'd0, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl.out_valid", {31'b0, out_valid}, 32'd0);
        chk("fl.in_ready",  {31'b0, in_ready},  32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl.nothing", {31'b0, out_valid}, 32'd0);
        end

        // Reset mid-stream while FULL with a concurrent input
        out_ready = 1'b0;
        present(32'h342200F0, 32'hA0A00000, 32'd0);
        step();
        present(32'h38238001, 32'hA0A00000, 32'd0);
        step();
        present(32'h3024FFFF, 32'hA0A00000, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk_reset_state("rst_mid");
        out_ready = 1'b1;
        step();
        chk("rst_mid.nothing", {31'b0, out_valid}, 32'd0);

        // Recovery after reset
        present(32'h3C011234, 32'd0, 32'd0);
        step();
        chk_out("recover", 13'h0001, 32'd0, 32'h00001234, 5'd1, 1'b0);
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
